rob_commit: RTL and testbench

//  Reorder buffer for the OoO RV32I core. Sits downstream of the CDB and upstream of the regfile.

---
 rtl/rob_commit.sv | 109 ++++++++++
 tb/tb_rob_commit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with CDB capture, mispredict flush and operand lookup
module rob_commit #(
    parameter int SIZE = 8,
    parameter int ID_W = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    input  logic [4:0]      alloc_rd,
    input  logic            alloc_is_br,
    output logic            alloc_ready,
    output logic [ID_W-1:0] alloc_id,
    input  logic            cdb_valid,
    input  logic [ID_W-1:0] cdb_id,
    input  logic [31:0]     cdb_data,
    input  logic            cdb_mispred,
    input  logic [31:0]     cdb_target,
    input  logic [ID_W-1:0] src1_id,
    input  logic [ID_W-1:0] src2_id,
    output logic            src1_ready,
    output logic            src2_ready,
    output logic [31:0]     src1_data,
    output logic [31:0]     src2_data,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [31:0]     commit_data,
    output logic [ID_W-1:0] commit_id,
    output logic            flush,
    output logic [31:0]     flush_pc,
    output logic [SIZE-1:0] flush_mask,
    output logic [ID_W:0]   count
);
    localparam logic [ID_W:0] PTR_ONE = 1;

    logic [ID_W:0]     head, tail;
    logic [SIZE-1:0]   busy, done, mispred, head_bit;
    logic [4:0]        rd [SIZE];
    logic [31:0]       data [SIZE];
    logic [31:0]       target [SIZE];
    logic [ID_W-1:0]   h, t;
    logic              full, do_alloc, do_cdb, unused_is_br;

    // pointer decode, retirement and flush decisions from registered state
    always_comb begin
        h = head[ID_W-1:0];
        t = tail[ID_W-1:0];
        full = (h == t) && (head[ID_W] != tail[ID_W]);
        commit_valid = busy[h] && done[h];
        flush = commit_valid && mispred[h];
        alloc_ready = !full && !flush;
        alloc_id = t;
        count = tail - head;
        commit_rd = commit_valid ? rd[h] : '0;
        commit_data = commit_valid ? data[h] : '0;
        commit_id = commit_valid ? h : '0;
        flush_pc = flush ? target[h] : '0;
        head_bit = '0;
        head_bit[h] = 1'b1;
        flush_mask = flush ? (busy & ~head_bit) : '0;
        do_alloc = alloc_req && alloc_ready;
        do_cdb = cdb_valid && busy[cdb_id] && !flush;
        unused_is_br = alloc_is_br;
    end

    // operand lookup: stored result first, then same-cycle CDB bypass
    always_comb begin
        src1_ready = done[src1_id] || (cdb_valid && cdb_id == src1_id);
        src2_ready = done[src2_id] || (cdb_valid && cdb_id == src2_id);
        src1_data = done[src1_id] ? data[src1_id] : (cdb_valid && cdb_id == src1_id) ? cdb_data : '0;
        src2_data = done[src2_id] ? data[src2_id] : (cdb_valid && cdb_id == src2_id) ? cdb_data : '0;
    end

    // entry state and pointers: flush squashes everything but retires head
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            done <= '0;
            mispred <= '0;
        end else if (flush) begin
            head <= head + PTR_ONE;
            tail <= head + PTR_ONE;
            busy <= '0;
            done <= '0;
            mispred <= '0;
        end else begin
            if (do_alloc) begin
                busy[t] <= 1'b1;
                done[t] <= 1'b0;
                mispred[t] <= 1'b0;
                rd[t] <= alloc_rd;
                tail <= tail + PTR_ONE;
            end
            if (do_cdb) begin
                done[cdb_id] <= 1'b1;
                data[cdb_id] <= cdb_data;
                mispred[cdb_id] <= cdb_mispred;
                target[cdb_id] <= cdb_target;
            end
            if (commit_valid) begin
                head <= head + PTR_ONE;
                busy[h] <= 1'b0;
                done[h] <= 1'b0;
                mispred[h] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and random checks of rob_commit against a queue-based model
module tb_rob_commit;
    logic        clk = 0, rst = 0;
    logic        alloc_req, alloc_is_br, alloc_ready;
    logic [4:0]  alloc_rd;
    logic [2:0]  alloc_id, cdb_id, src1_id, src2_id, commit_id;
    logic        cdb_valid, cdb_mispred;
    logic [31:0] cdb_data, cdb_target;
    logic        src1_ready, src2_ready, commit_valid, flush;
    logic [31:0] src1_data, src2_data, commit_data, flush_pc;
    logic [4:0]  commit_rd;
    logic [7:0]  flush_mask;
    logic [3:0]  count;

    rob_commit dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
        .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .src1_id(src1_id), .src2_id(src2_id),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .src1_data(src1_data), .src2_data(src2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_id(commit_id), .flush(flush), .flush_pc(flush_pc),
        .flush_mask(flush_mask), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        done;
        logic [31:0] data;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   head_seq = 0;
    bit   known = 0;
    int   n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] lookup(input logic [2:0] src);
        for (int i = 0; i < q.size(); i++)
            if ((head_seq + i) % 8 == int'(src) && q[i].done) return {1'b1, q[i].data};
        if (cdb_valid && cdb_id == src) return {1'b1, cdb_data};
        return 33'd0;
    endfunction

    task automatic check_outputs();
        int sz = q.size();
        logic ec, ef;
        logic [7:0] mask = 8'd0;
        logic [32:0] l1, l2;
        ec = sz > 0 && q[0].done;
        ef = ec && q[0].mis;
        for (int i = 1; i < sz; i++) mask[(head_seq + i) % 8] = ef;
        l1 = lookup(src1_id);
        l2 = lookup(src2_id);
        chk("alloc_ready", alloc_ready, (sz != 8) && !ef);
        chk("alloc_id", alloc_id, (head_seq + sz) % 8);
        chk("count", count, sz);
        chk("commit_valid", commit_valid, ec);
        chk("commit_rd", commit_rd, ec ? q[0].rd : 5'd0);
        chk("commit_data", commit_data, ec ? q[0].data : 32'd0);
        chk("commit_id", commit_id, ec ? head_seq : 0);
        chk("flush", flush, ef);
        chk("flush_pc", flush_pc, ef ? q[0].tgt : 32'd0);
        chk("flush_mask", flush_mask, mask);
        chk("src1_ready", src1_ready, l1[32]);
        chk("src1_data", src1_data, l1[31:0]);
        chk("src2_ready", src2_ready, l2[32]);
        chk("src2_data", src2_data, l2[31:0]);
    endtask

    task automatic update_model();
        int sz = q.size();
        logic ec, ef;
        int idx;
        ec = sz > 0 && q[0].done;
        ef = ec && q[0].mis;
        if (rst) begin
            q.delete();
            head_seq = 0;
            known = 1;
        end else if (ef) begin
            q.delete();
            head_seq = (head_seq + 1) % 8;
        end else begin
            if (cdb_valid) begin
                idx = (int'(cdb_id) - head_seq + 8) % 8;
                if (idx < sz) begin
                    q[idx].done = 1;
                    q[idx].data = cdb_data;
                    q[idx].mis = cdb_mispred;
                    q[idx].tgt = cdb_target;
                end
            end
            if (ec) begin
                void'(q.pop_front());
                head_seq = (head_seq + 1) % 8;
            end
            if (alloc_req && sz != 8) q.push_back('{alloc_rd, 1'b0, 32'd0, 1'b0, 32'd0});
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (known) check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 0; alloc_rd = 0; alloc_is_br = 0;
        cdb_valid = 0; cdb_id = 0; cdb_data = 0; cdb_mispred = 0; cdb_target = 0;
        src1_id = 0; src2_id = 0;
    endtask

    task automatic cdb(input int id, input logic [31:0] d, input logic m = 0, input logic [31:0] t = 0);
        cdb_valid = 1; cdb_id = id[2:0]; cdb_data = d; cdb_mispred = m; cdb_target = t;
    endtask

    function automatic int tail_id();
        return (head_seq + q.size()) % 8;
    endfunction

    initial begin
        int id;
        idle();
        rst = 1; step(); rst = 0;
        for (int i = 1; i <= 8; i++) begin
            alloc_req = 1; alloc_rd = i[4:0]; alloc_is_br = (i == 5); step();
        end
        alloc_rd = 9; step();
        idle();
        cdb(2, 32'h30); step();
        cdb(1, 32'h20); step();
        cdb(0, 32'h10); step();
        idle();
        step(); step(); step();
        cdb(3, 32'hDEADBEEF); src1_id = 3; src2_id = 4; step();
        cdb_valid = 0; step();
        idle();
        cdb(4, 32'h44, 1, 32'h60000040); step();
        idle();
        alloc_req = 1; alloc_rd = 3; cdb(5, 32'h55); src1_id = 5; step();
        idle(); step();
        for (int i = 0; i < 20; i++) begin
            id = tail_id();
            alloc_req = 1; alloc_rd = 5'($urandom_range(0, 31)); step();
            idle(); cdb(id, $urandom); src2_id = id[2:0]; step();
            idle(); step();
        end
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1; alloc_rd = i[4:0]; step();
        end
        idle(); cdb(head_seq, 32'hA5A5A5A5); step();
        idle(); alloc_req = 1; alloc_rd = 5'd17; step();
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            cdb((head_seq + k + (q.size() < 8 ? -1 : 0) + 8) % 8, $urandom); step();
        end
        idle(); step(); step(); step(); step();
        cdb(head_seq, 32'h77); step();
        idle(); rst = 1; step(); rst = 0; step();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            alloc_req = $urandom_range(0, 1) == 1;
            alloc_rd = 5'($urandom_range(0, 31));
            alloc_is_br = $urandom_range(0, 3) == 0;
            cdb_valid = $urandom_range(0, 1) == 1;
            cdb_id = $urandom_range(0, 1) == 1 ? 3'((head_seq + $urandom_range(0, 2)) % 8) : 3'($urandom_range(0, 7));
            cdb_data = $urandom;
            cdb_mispred = $urandom_range(0, 7) == 0;
            cdb_target = $urandom;
            src1_id = 3'($urandom_range(0, 7));
            src2_id = 3'($urandom_range(0, 7));
            step();
        end
        rst = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
